// File: rtl/branch_flag_gen.sv
// Serial rs1 - rs2 comparator producing {Z, LT, BORROW, V} branch flags, CHUNK_W bits per cycle.
// Define BFG_PERF_CNT_EN to add the cmp_count completed-compare counter port.
module branch_flag_gen #(
    parameter int XLEN    = 32,
    parameter int CHUNK_W = 8   // XLEN must be a multiple of CHUNK_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [3:0]      func,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      flag
`ifdef BFG_PERF_CNT_EN
    ,
    output logic [31:0]     cmp_count
`endif
);

    localparam int N     = XLEN / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic             unsigned_q;
    logic             carry_q;
    logic             zacc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CHUNK_W:0]   sum;
    logic [CHUNK_W-1:0] d;
    logic               cout;
    logic               z_next;
    logic               n_bit;
    logic               cin_msb;
    logic               v_bit;
    logic               borrow;
    logic               lt_bit;
    logic               release_out;
    logic               accept;
    logic               unused_func;

    // Operands shift right every BUSY cycle, so the active chunk is always the low slice.
    assign sum     = {1'b0, a_q[CHUNK_W-1:0]} + {1'b0, b_q[CHUNK_W-1:0]} + {{CHUNK_W{1'b0}}, carry_q};
    assign d       = sum[CHUNK_W-1:0];
    assign cout    = sum[CHUNK_W];
    assign z_next  = zacc_q & (d == '0);
    assign n_bit   = d[CHUNK_W-1];
    // The carry into a sum bit is recovered as sum ^ a ^ b.
    assign cin_msb = d[CHUNK_W-1] ^ a_q[CHUNK_W-1] ^ b_q[CHUNK_W-1];
    assign v_bit   = cin_msb ^ cout;
    assign borrow  = ~cout;
    assign lt_bit  = unsigned_q ? borrow : (n_bit ^ v_bit);

    assign release_out = (state == DONE) && out_ready;
    assign in_ready    = (state == IDLE) || release_out;
    assign accept      = in_valid && in_ready;

    // Only func[1] affects the result; the remaining bits are deliberately ignored.
    assign unused_func = ^{func[3:2], func[0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            flag       <= 4'b0000;
            cnt_q      <= '0;
            carry_q    <= 1'b1;
            zacc_q     <= 1'b1;
            unsigned_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            case (state)
                BUSY: begin
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    carry_q <= cout;
                    zacc_q  <= z_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        flag      <= {z_next, lt_bit, borrow, v_bit};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase

            // A new op may be taken in IDLE or in the same edge that retires DONE.
            if (accept) begin
                a_q        <= rs1;
                b_q        <= ~rs2;
                unsigned_q <= func[1];
                carry_q    <= 1'b1;
                zacc_q     <= 1'b1;
                cnt_q      <= '0;
                state      <= BUSY;
            end
        end
    end

`ifdef BFG_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_count <= 32'd0;
        end else if (out_valid && out_ready) begin
            cmp_count <= cmp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_flag_gen.sv
// Directed-vector bench for branch_flag_gen (XLEN=32, CHUNK_W=8).
// Define BFG_PERF_CNT_EN to also check the compare counter.
module tb_branch_flag_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  func;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  flag;
`ifdef BFG_PERF_CNT_EN
    logic [31:0] cmp_count;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int exp_cmp  = 0;

    branch_flag_gen #(.XLEN(32), .CHUNK_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag      (flag)
`ifdef BFG_PERF_CNT_EN
        ,
        .cmp_count (cmp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after the accept edge; counts edges until out_valid is seen.
    task automatic wait_done(input string tag);
        int lat = 0;
        while (lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_lat"}, lat, 4);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                          input logic [3:0] exp_flag, input string tag);
        @(negedge clk);
        rs1      = a;
        rs2      = b;
        func     = f;
        in_valid = 1'b1;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        func     = 4'hf;
        check({tag, "_busy"}, in_ready, 0);
        wait_done(tag);
        check({tag, "_flag"}, flag, exp_flag);
        @(posedge clk);
        #1;
        exp_cmp++;
        check({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        logic saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rs1       = '0;
        rs2       = '0;
        func      = '0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_flag", flag, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", in_ready, 1);
`ifdef BFG_PERF_CNT_EN
        check("rst_cnt", cmp_count, 0);
`endif

        // Basic flag arithmetic
        run_op(32'h1234_5678, 32'h1234_5678, 4'b0000, 4'b1000, "eq_s");
        run_op(32'h1234_5678, 32'h1234_5678, 4'b0110, 4'b1000, "eq_u");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 4'b0100, "m1_s");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0110, 4'b0000, "m1_u");
        run_op(32'h8000_0000, 32'h0000_0001, 4'b0100, 4'b0101, "ovf");
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 4'b0100, 4'b0010, "p1m1_s");
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 4'b0110, 4'b0110, "p1m1_u");
        run_op(32'h0000_0001, 32'h0000_0002, 4'b0010, 4'b0110, "f3_u");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1100, 4'b0100, "f3ign");

        // Output stall, input ignored while busy, back-to-back accept
        out_ready = 1'b0;
        @(negedge clk);
        rs1 = 32'h1; rs2 = 32'h2; func = 4'b0110; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rs1 = 32'h3; rs2 = 32'h3; func = 4'b0000;
        wait_done("stall");
        check("stall_flag", flag, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_ov", out_valid, 1);
            check("stall_fl", flag, 4'b0110);
            check("stall_rdy", in_ready, 0);
`ifdef BFG_PERF_CNT_EN
            check("stall_cnt", cmp_count, exp_cmp);
`endif
        end
        out_ready = 1'b1;
        #1;
        check("b2b_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        exp_cmp++;
        in_valid = 1'b0;
        rs1 = 32'hDEAD_BEEF; rs2 = 32'h0; func = 4'b0110;
        check("b2b_ov", out_valid, 0);
        check("b2b_busy", in_ready, 0);
        wait_done("b2b");
        check("b2b_flag", flag, 4'b1000);
        @(posedge clk);
        #1;
        exp_cmp++;
`ifdef BFG_PERF_CNT_EN
        check("cnt_mid", cmp_count, exp_cmp);
`endif

        // Reset in the second BUSY cycle aborts the op
        @(negedge clk);
        rs1 = 32'h5; rs2 = 32'h9; func = 4'b0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ov", out_valid, 0);
        check("abort_fl", flag, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_rdy", in_ready, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | out_valid;
        end
        check("abort_stale", saw_valid, 0);
        exp_cmp = 0;

        // Five compares after reset
        run_op(32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b1000, "r0");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0100, 4'b0011, "r1");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0110, 4'b0111, "r2");
        run_op(32'h0000_0100, 32'h0000_00FF, 4'b0110, 4'b0000, "r3");
        run_op(32'h0000_00FF, 32'h0000_0100, 4'b0100, 4'b0110, "r4");
`ifdef BFG_PERF_CNT_EN
        check("cnt_five", cmp_count, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
